// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce; emits one hex code per accepted press.
// Columns are driven active-low one at a time; rows are read back through a 2-flop synchronizer.
module keypad_scan #(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t           state;
    logic [3:0]       rs_meta;
    logic [3:0]       rs;
    logic [3:0]       latched;
    logic [DIV_W-1:0] div;
    logic [DB_W-1:0]  db;
    logic [3:0]       next_cols;

    function automatic logic one_low(input logic [3:0] p);
        return (p == 4'b1110) || (p == 4'b1101) || (p == 4'b1011) || (p == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] p);
        case (p)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return 4'hE;
            4'hD: return 4'h0;
            4'hE: return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    // Rotating the active-low column pattern left walks the scan 0,1,2,3,0.
    assign next_cols = {cols[2:0], cols[3]};

    always_ff @(posedge clk) begin
        rs_meta <= rows;
        rs      <= rs_meta;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            cols      <= 4'b1110;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            div       <= '0;
            db        <= '0;
            latched   <= 4'hF;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (one_low(rs)) begin
                            latched <= rs;
                            db      <= '0;
                            state   <= PRESS_DB;
                        end else begin
                            cols <= next_cols;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (rs != latched) begin
                        div   <= '0;
                        cols  <= next_cols;
                        state <= SCAN;
                    end else if (db == DB_LAST) begin
                        key       <= key_map(low_index(latched), low_index(cols));
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        db        <= '0;
                        state     <= HELD;
                    end else begin
                        db <= db + 1'b1;
                    end
                end
                HELD: begin
                    if (rs == 4'hF) begin
                        db    <= '0;
                        state <= REL_DB;
                    end
                end
                REL_DB: begin
                    // Any low row during release debounce is a bounce, not a new press.
                    if (rs != 4'hF) begin
                        db    <= '0;
                        state <= HELD;
                    end else if (db == DB_LAST) begin
                        key_held <= 1'b0;
                        div      <= '0;
                        db       <= '0;
                        cols     <= next_cols;
                        state    <= SCAN;
                    end else begin
                        db <= db + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
